// File: rtl/adc_pkg.sv
// Shared types, defaults and helpers for the ADC stream frame packer.
package adc_pkg;

  typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;

  localparam int ADC_DATA_W = 12;
  localparam int ADC_CH_W   = 5;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/adc_sc_fifo.sv
// Single-clock show-ahead FIFO: rd_data presents the head word whenever not empty.
module adc_sc_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   free
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             full;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign free    = (AW+1)'(DEPTH) - count;
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/adc_stream_frame_packer.sv
// Windows, averages and packs ADC channel samples into SOP/EOP framed packets
// behind an output FIFO.
module adc_stream_frame_packer
  import adc_pkg::*;
#(
  parameter int DATA_W     = ADC_DATA_W,
  parameter int CH_W       = ADC_CH_W,
  parameter int NUM_CH     = 4,
  parameter int CH_BASE    = 0,
  parameter int AVG_LOG2   = 2,
  parameter int OUT_W      = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              cfg_enable,
  input  logic              cfg_signed,
  input  logic              in_valid,
  input  logic [CH_W-1:0]   in_channel,
  input  logic [DATA_W-1:0] in_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out_data,
  output logic [CH_W-1:0]   out_channel,
  output logic              out_startofpacket,
  output logic              out_endofpacket,
  output logic [15:0]       drop_count,
  output logic [15:0]       resync_count
);

  localparam int ACC_W  = DATA_W + AVG_LOG2;
  localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SCAN_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int WORD_W = OUT_W + CH_W + 2;
  localparam int FREE_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'((1 << AVG_LOG2) - 1);
  localparam logic [CH_W:0]     WIN_LO    = (CH_W+1)'(CH_BASE);
  localparam logic [CH_W:0]     WIN_HI    = (CH_W+1)'(CH_BASE + NUM_CH);
  localparam logic [CH_W-1:0]   LAST_IDX  = CH_W'(NUM_CH - 1);

  state_t              state, state_nx;
  logic [CH_W-1:0]     exp_idx;
  logic [SCAN_W-1:0]   scan;
  logic                drop_frame;
  logic [ACC_W-1:0]    acc [1 << IDX_W];
  logic                push_valid;
  logic [WORD_W-1:0]   push_word;

  logic [CH_W:0]       ch_ext;
  logic                relevant;
  logic [CH_W-1:0]     idx;
  logic [IDX_W-1:0]    idx_s;
  logic                first_idx, last_idx, final_scan;
  logic                accept, mismatch;
  logic [ACC_W-1:0]    sum;
  logic [DATA_W-1:0]   avg;
  logic [OUT_W-1:0]    converted;
  logic [FREE_W-1:0]   fifo_free, free_eff;
  logic                space_ok, drop_now;
  logic                fifo_empty;
  logic [WORD_W-1:0]   fifo_word;

  assign ch_ext     = {1'b0, in_channel};
  assign relevant   = in_valid && (ch_ext >= WIN_LO) && (ch_ext < WIN_HI);
  assign idx        = in_channel - CH_W'(CH_BASE);
  assign idx_s      = idx[IDX_W-1:0];
  assign first_idx  = (idx == '0);
  assign last_idx   = (idx == LAST_IDX);
  assign final_scan = (scan == SCAN_LAST);
  assign sum        = acc[idx_s] + ACC_W'(in_data);
  assign avg        = DATA_W'(sum >> AVG_LOG2);
  // Subtracting midscale is an MSB flip; the flipped MSB is then the sign.
  assign converted  = cfg_signed
                    ? {{(OUT_W-DATA_W+1){~avg[DATA_W-1]}}, avg[DATA_W-2:0]}
                    : OUT_W'(avg);

  // A word still sitting in the push register already owns a FIFO slot.
  assign free_eff = fifo_free - FREE_W'(push_valid);
  assign space_ok = (free_eff >= FREE_W'(NUM_CH));
  assign drop_now = first_idx ? !space_ok : drop_frame;

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    mismatch = 1'b0;
    case (state)
      IDLE: if (cfg_enable) state_nx = SYNC;
      SYNC: begin
        if (!cfg_enable) begin
          state_nx = IDLE;
        end else if (relevant && first_idx) begin
          accept   = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (relevant) begin
          if (idx == exp_idx) begin
            accept = 1'b1;
            if (last_idx && !cfg_enable) state_nx = IDLE;
          end else begin
            mismatch = 1'b1;
            state_nx = SYNC;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state        <= IDLE;
      exp_idx      <= '0;
      scan         <= '0;
      drop_frame   <= 1'b0;
      push_valid   <= 1'b0;
      push_word    <= '0;
      drop_count   <= '0;
      resync_count <= '0;
      for (int i = 0; i < (1 << IDX_W); i++) acc[i] <= '0;
    end else begin
      state      <= state_nx;
      push_valid <= accept && final_scan && !drop_now;
      push_word  <= {converted, in_channel, first_idx, last_idx};
      if (accept) begin
        acc[idx_s] <= final_scan ? '0 : sum;
        exp_idx    <= last_idx ? '0 : idx + CH_W'(1);
        if (last_idx) scan <= final_scan ? '0 : scan + SCAN_W'(1);
        if (final_scan && first_idx) begin
          drop_frame <= !space_ok;
          if (!space_ok) drop_count <= sat_inc16(drop_count);
        end
      end
      if (mismatch) resync_count <= sat_inc16(resync_count);
      // Every fresh sync starts from empty accumulators at scan 0.
      if (mismatch || state == IDLE) begin
        exp_idx    <= '0;
        scan       <= '0;
        drop_frame <= 1'b0;
        for (int i = 0; i < (1 << IDX_W); i++) acc[i] <= '0;
      end
    end
  end

  // out_valid/out_ready: a word transfers on a cycle where both are high;
  // while out_valid && !out_ready the head word and all out_* hold.
  adc_sc_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_clk),
    .rst     (reset_reset),
    .wr_en   (push_valid),
    .wr_data (push_word),
    .rd_en   (out_valid && out_ready),
    .rd_data (fifo_word),
    .empty   (fifo_empty),
    .free    (fifo_free)
  );

  assign out_valid = !fifo_empty;
  assign {out_data, out_channel, out_startofpacket, out_endofpacket} =
    out_valid ? fifo_word : '0;

endmodule
